// File: rtl/tmds_shift_scheduler.sv
// Serialises buffered per-pixel TMDS symbol triples, together with the TMDS clock pattern,
// into 2-bit (DDR) or 1-bit (SDR) slices; substitutes an idle control symbol on underflow.
module tmds_shift_scheduler #(
  parameter bit          C_ddr         = 1'b1,
  parameter logic [9:0]  C_idle_symbol = 10'b1101010100
) (
  input  logic        clk_shift,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_red,
  input  logic [9:0]  in_green,
  input  logic [9:0]  in_blue,
  output logic [1:0]  out_clock,
  output logic [1:0]  out_red,
  output logic [1:0]  out_green,
  output logic [1:0]  out_blue,
  output logic        word_start,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  localparam int         N           = C_ddr ? 5 : 10;
  localparam logic [3:0] LAST_PHASE  = 4'(N - 1);
  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

  logic [3:0]  phase;
  logic        buf_full;
  logic [9:0]  buf_red, buf_green, buf_blue;
  logic [9:0]  sh_clock, sh_red, sh_green, sh_blue;
  logic [15:0] uf_count;
  logic        last, accept, bypass;

  function automatic logic [9:0] shift_down(input logic [9:0] v);
    return C_ddr ? {2'b00, v[9:2]} : {1'b0, v[9:1]};
  endfunction

  function automatic logic [1:0] slice(input logic [9:0] v);
    return C_ddr ? v[1:0] : {1'b0, v[0]};
  endfunction

  assign last     = (phase == LAST_PHASE);
  assign in_ready = !buf_full || last;
  assign accept   = in_valid && in_ready;
  // A triple arriving in the reload cycle with nothing buffered goes straight to the shifters.
  assign bypass   = accept && last && !buf_full;

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      phase     <= '0;
      buf_full  <= 1'b0;
      buf_red   <= C_idle_symbol;
      buf_green <= C_idle_symbol;
      buf_blue  <= C_idle_symbol;
      sh_clock  <= CLK_PATTERN;
      sh_red    <= C_idle_symbol;
      sh_green  <= C_idle_symbol;
      sh_blue   <= C_idle_symbol;
      underflow <= 1'b0;
      uf_count  <= '0;
    end else begin
      underflow <= 1'b0;
      if (last) begin
        phase    <= '0;
        sh_clock <= CLK_PATTERN;
        if (buf_full) begin
          sh_red   <= buf_red;
          sh_green <= buf_green;
          sh_blue  <= buf_blue;
        end else if (accept) begin
          sh_red   <= in_red;
          sh_green <= in_green;
          sh_blue  <= in_blue;
        end else begin
          sh_red    <= C_idle_symbol;
          sh_green  <= C_idle_symbol;
          sh_blue   <= C_idle_symbol;
          underflow <= 1'b1;
          if (uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
        end
      end else begin
        phase    <= phase + 4'd1;
        sh_clock <= shift_down(sh_clock);
        sh_red   <= shift_down(sh_red);
        sh_green <= shift_down(sh_green);
        sh_blue  <= shift_down(sh_blue);
      end

      // Refill on the same edge that drains keeps a full buffer full.
      if (accept && !bypass) begin
        buf_red   <= in_red;
        buf_green <= in_green;
        buf_blue  <= in_blue;
        buf_full  <= 1'b1;
      end else if (last && buf_full) begin
        buf_full  <= 1'b0;
      end
    end
  end

  assign out_clock       = slice(sh_clock);
  assign out_red         = slice(sh_red);
  assign out_green       = slice(sh_green);
  assign out_blue        = slice(sh_blue);
  assign word_start      = (phase == 4'd0);
  assign underflow_count = uf_count;

endmodule

// File: tb/tb_tmds_shift_scheduler.sv
// Scoreboard bench: accepted triples are queued by the driver and checked slice-by-slice by a
// negedge monitor on the DDR instance; a second SDR instance covers 1-bit mode and saturation.
module tb_tmds_shift_scheduler;

  localparam int         N       = 5;
  localparam logic [9:0] IDLE    = 10'b1101010100;
  localparam logic [9:0] CLK_PAT = 10'b0000011111;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } triple_t;

  logic clk_shift = 1'b0;
  initial forever #5 clk_shift = ~clk_shift;

  logic        reset, in_valid, in_ready, word_start, underflow;
  logic [9:0]  in_red, in_green, in_blue;
  logic [1:0]  out_clock, out_red, out_green, out_blue;
  logic [15:0] underflow_count;

  logic        reset_s, in_valid_s, in_ready_s, word_start_s, underflow_s;
  logic [9:0]  in_red_s, in_green_s, in_blue_s;
  logic [1:0]  out_clock_s, out_red_s, out_green_s, out_blue_s;
  logic [15:0] underflow_count_s;

  tmds_shift_scheduler #(.C_ddr(1'b1), .C_idle_symbol(IDLE)) dut (
    .clk_shift(clk_shift), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_clock(out_clock), .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .word_start(word_start), .underflow(underflow), .underflow_count(underflow_count));

  tmds_shift_scheduler #(.C_ddr(1'b0), .C_idle_symbol(IDLE)) dut_s (
    .clk_shift(clk_shift), .reset(reset_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_red(in_red_s), .in_green(in_green_s), .in_blue(in_blue_s),
    .out_clock(out_clock_s), .out_red(out_red_s), .out_green(out_green_s), .out_blue(out_blue_s),
    .word_start(word_start_s), .underflow(underflow_s), .underflow_count(underflow_count_s));

  int      checks = 0;
  int      failures = 0;
  triple_t exp_q[$];
  int      mphase = 0;
  bit      started = 1'b0;
  int      model_count = 0;
  bit      exp_uf;
  triple_t cur;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Monitor: tracks its own phase and compares every slice against the scoreboard symbol.
  always @(negedge clk_shift) begin
    if (reset) begin
      started     = 1'b1;
      mphase      = 0;
      model_count = 0;
      exp_uf      = 1'b0;
      cur         = '{r: IDLE, g: IDLE, b: IDLE};
    end else if (started) begin
      mphase = (mphase == N - 1) ? 0 : mphase + 1;
      exp_uf = 1'b0;
      if (mphase == 0) begin
        if (exp_q.size() == 0) begin
          cur    = '{r: IDLE, g: IDLE, b: IDLE};
          exp_uf = 1'b1;
          if (model_count < 65535) model_count++;
        end else begin
          cur = exp_q.pop_front();
        end
      end
    end
    if (started) begin
      checkOutput("underflow", int'(underflow), int'(exp_uf));
      checkOutput("underflow_count", int'(underflow_count), model_count);
      checkOutput("word_start", int'(word_start), int'(mphase == 0));
      checkOutput("in_ready", int'(in_ready), int'(exp_q.size() == 0 || mphase == N - 1));
      checkOutput("out_clock", int'(out_clock), int'(CLK_PAT[2*mphase +: 2]));
      checkOutput("out_red", int'(out_red), int'(cur.r[2*mphase +: 2]));
      checkOutput("out_green", int'(out_green), int'(cur.g[2*mphase +: 2]));
      checkOutput("out_blue", int'(out_blue), int'(cur.b[2*mphase +: 2]));
    end
  end

  task automatic applyStimulus(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_red   = r;
    in_green = g;
    in_blue  = b;
    for (int k = 0; k < 3 * N && !ok; k++) begin
      ok = in_ready;
      if (ok) exp_q.push_back('{r: r, g: g, b: b});
      @(negedge clk_shift); #2;
    end
    in_valid = 1'b0;
    checkOutput("accept", int'(ok), 1);
  endtask

  task automatic waitPhase(input int p);
    bit hit = 1'b0;
    for (int k = 0; k < 2 * N && !hit; k++) begin
      if (mphase == p) hit = 1'b1;
      else begin
        @(negedge clk_shift); #2;
      end
    end
    checkOutput("wait_phase", int'(hit), 1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk_shift); #2;
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] idle_v;
    logic [9:0] clk_v;
    idle_v = IDLE;
    clk_v  = CLK_PAT;
    reset = 1'b1; in_valid = 1'b0; in_red = '0; in_green = '0; in_blue = '0;
    reset_s = 1'b1; in_valid_s = 1'b0; in_red_s = '0; in_green_s = '0; in_blue_s = '0;
    repeat (2) @(negedge clk_shift);
    #2 reset = 1'b0;

    // Idle after reset: underflows at cycles 5 and 10, none for the reset symbol.
    idleCycles(14);
    checkOutput("idle_uf_count", int'(underflow_count), 2);

    // Single triple accepted at phase 2 appears three cycles later.
    waitPhase(2);
    applyStimulus(10'h3FF, 10'h000, 10'h155);
    idleCycles(2);
    checkOutput("single_word_start", int'(word_start), 1);
    checkOutput("single_red", int'(out_red), 2'b11);
    checkOutput("single_blue", int'(out_blue), 2'b01);
    checkOutput("single_no_uf", int'(underflow), 0);
    idleCycles(10);

    // Back-to-back streaming of 20 distinct triples.
    for (int i = 0; i < 20; i++)
      applyStimulus(10'(i * 7 + 1), 10'(i * 13 + 2), 10'(1000 - i * 11));
    idleCycles(12);

    // Buffer full with A while B is offered in the reload cycle.
    waitPhase(1);
    applyStimulus(10'h2A5, 10'h15A, 10'h0F0);
    applyStimulus(10'h1C3, 10'h33C, 10'h00F);
    idleCycles(15);

    // Reset at phase 3 with a buffered triple: both in-flight and buffered data vanish.
    waitPhase(0);
    applyStimulus(10'h111, 10'h222, 10'h333);
    applyStimulus(10'h0AA, 10'h155, 10'h3C3);
    waitPhase(3);
    reset = 1'b1;
    exp_q.delete();
    idleCycles(1);
    checkOutput("rst_word_start", int'(word_start), 1);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_uf_count", int'(underflow_count), 0);
    checkOutput("rst_out_clock", int'(out_clock), 2'b11);
    checkOutput("rst_out_red", int'(out_red), 2'b00);
    reset = 1'b0;
    idleCycles(15);

    // SDR instance: 10-cycle period, upper bit always zero.
    reset_s = 1'b0;
    for (int c = 0; c < 30; c++) begin
      int ph;
      ph = c % 10;
      checkOutput("sdr_clock", int'(out_clock_s), int'(clk_v[ph]));
      checkOutput("sdr_red", int'(out_red_s), int'(idle_v[ph]));
      checkOutput("sdr_blue", int'(out_blue_s), int'(idle_v[ph]));
      checkOutput("sdr_word_start", int'(word_start_s), int'(ph == 0));
      checkOutput("sdr_underflow", int'(underflow_s), int'(ph == 0 && c > 0));
      idleCycles(1);
    end
    checkOutput("sdr_uf_count", int'(underflow_count_s), 3);
    idleCycles(1);
    force dut_s.uf_count = 16'hFFFE;
    #1;
    release dut_s.uf_count;
    idleCycles(8);
    checkOutput("sat_preset", int'(underflow_count_s), 16'hFFFE);
    idleCycles(1);
    checkOutput("sat_reach", int'(underflow_count_s), 16'hFFFF);
    checkOutput("sat_pulse", int'(underflow_s), 1);
    idleCycles(10);
    checkOutput("sat_hold", int'(underflow_count_s), 16'hFFFF);
    checkOutput("sat_pulse2", int'(underflow_s), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
